passcode_programmer: RTL
========================

# passcode_programmer

Writer side of the passcode lock. Lets an already-unlocked user enter a new 4-digit passcode on the switches, then re-enter it to confirm. Commits the code only when both entries match. Drives the stored code to the passcode checker, which reads it in place of fixed constants.

## Interface
Parameters:
- DEFAULT_CODE, 16'h1224, code loaded at reset; digit A in [15:12], B [11:8], C [7:4], D [3:0]
- TIMEOUT_CYCLES, 1_000_000_000, idle cycles allowed between accepted presses (20 s at 50 MHz); must be ≥ 2

Ports. Clock: clk. Reset: rst, synchronous and active-high.
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- btn0  input  1  raw push button, active-low
- SW  input  4  digit value, sampled on an accepted press
- prog_en  input  1  programming permitted (tied to checker's passcode_correct)
- code  output  16  stored passcode, registered
- prog_state  output  2  0=IDLE, 1=NEW, 2=CONFIRM
- digit_idx  output  2  index of the next digit to be entered (0..3)
- prog_done  output  1  one-cycle pulse: new code committed
- prog_error  output  1  one-cycle pulse: mismatch, abort or timeout
- led  output  4  one-hot digit_idx (led[3]=idx0) while not IDLE; 0 in IDLE

## Operation
- Button one-shot: s1 <= ~btn0; s2 <= s1; press = s1 & ~s2. One press per low-going edge; holding the button gives exactly one press.
- Staging register stage[15:0] and mismatch flag mm are internal.
- IDLE:
  - press & prog_en → NEW, idx=0, mm=0.
  - This start press is not a digit.
- NEW, on each press:
  - stage[digit idx] <= SW; idx++.
  - On idx==3 → CONFIRM, idx=0.
- CONFIRM, on each press:
  - mm <= mm | (SW != stage[digit idx]); idx++.
  - All 4 digits are always collected; a mismatch is never revealed early.
  - On idx==3, evaluate with the current digit included:
    - no mismatch → code <= stage, prog_done, → IDLE.
    - else → prog_error, code unchanged, → IDLE.
- Abort: prog_en low in NEW or CONFIRM → IDLE, prog_error, code unchanged, stage discarded.
- Priority in one cycle:
  - rst > abort (prog_en low) > press > timeout.
  - A press in the timeout cycle is accepted and reloads the counter.
- prog_en is ignored in IDLE except as the entry qualifier. A press in IDLE with prog_en=0 does nothing.

## Timing
- Reset values:
  - code=DEFAULT_CODE, prog_state=IDLE, digit_idx=0.
  - prog_done=0, prog_error=0, led=0, stage=0, mm=0, s1=s2=0, timeout counter=0.
  - A reset mid-entry discards the entry. It also restores DEFAULT_CODE; a programmed code does not survive reset.
- Button latency:
  - btn0 sampled low at edge k → press high in cycle k..k+1.
  - FSM/registers update at edge k+1.
- prog_done and prog_error are registered. They assert in the cycle following the state transition edge, for exactly one cycle. Never both together.
- code changes at the same edge the FSM returns to IDLE from CONFIRM with a match. It is stable at all other times.
- digit_idx wraps 3→0 only via the NEW→CONFIRM or CONFIRM→IDLE transitions. It is reset to 0 whenever IDLE is entered.
- Timeout counter:
  - Cleared on entering NEW and on every accepted press.
  - Increments every cycle in NEW or CONFIRM, saturating.
  - On reaching TIMEOUT_CYCLES-1 with no press → IDLE plus prog_error.

## Configuration
- PASSCODE_PROG_TIMEOUT_EN:
  - Defined: timeout counter and timeout abort present as above.
  - Undefined: counter not built, TIMEOUT_CYCLES unused; entry waits indefinitely and exits only by completion, prog_en low, or rst.

## Test plan
Bench uses TIMEOUT_CYCLES=100 with PASSCODE_PROG_TIMEOUT_EN defined, unless stated otherwise.
- Reset, then read code → 16'h1224, prog_state=0, led=0, no pulses.
- prog_en=1; start press; enter 3,7,0,F; confirm 3,7,0,F → prog_done one cycle, code=16'h370F, prog_state=0.
- Same flow, confirm 3,7,1,F → prog_state stays 2 through all 4 confirm presses, then prog_error one cycle, code=16'h1224.
- Start, enter 2 digits, drop prog_en → IDLE next edge, prog_error, code unchanged. Also: button held low 50 cycles yields one digit only.
- Start, 1 digit, no press for 100 cycles → prog_error, IDLE. Press at cycle 99 → no timeout, digit_idx=2. Build without the macro: 1000-cycle wait stays in NEW.
- rst asserted in CONFIRM after a prior commit of 16'h370F → IDLE, code=16'h1224, digit_idx=0.

Source files
------------

// File: rtl/passcode_programmer.sv
// passcode_programmer
//   Writer side of the passcode lock. An unlocked user (prog_en high) presses
//   the button once to start. The user then enters four new digits on SW and
//   re-enters the same four digits to confirm. The staged code is committed to
//   `code` only when both entries match. `code` feeds the passcode checker in
//   place of fixed constants.
//
//   Optional feature macro: PASSCODE_PROG_TIMEOUT_EN
//     defined   - an inactivity timeout aborts entry after TIMEOUT_CYCLES idle cycles
//     undefined - no timeout counter; entry ends only by completion, prog_en low or rst
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for a start press while prog_en is high
//   ST_NEW     | collecting the four digits of the new code into stage
//   ST_CONFIRM | collecting four confirmation digits, accumulating mismatch
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   btn0       in   raw push button, active-low
//   SW[3:0]    in   digit value, sampled on an accepted press
//   prog_en    in   programming permitted (checker's passcode_correct)
//   code[15:0] out  stored passcode (A=[15:12] .. D=[3:0])
//   prog_state out  0=IDLE 1=NEW 2=CONFIRM
//   digit_idx  out  index of the next digit to be entered
//   prog_done  out  one-cycle pulse, new code committed
//   prog_error out  one-cycle pulse, mismatch / abort / timeout
//   led[3:0]   out  one-hot digit_idx (led[3] = idx 0) outside IDLE, else 0
module passcode_programmer #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1224,
  parameter int          TIMEOUT_CYCLES = 1_000_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn0,
  input  logic [3:0]  SW,
  input  logic        prog_en,
  output logic [15:0] code,
  output logic [1:0]  prog_state,
  output logic [1:0]  digit_idx,
  output logic        prog_done,
  output logic        prog_error,
  output logic [3:0]  led
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NEW     = 2'd1,
    ST_CONFIRM = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("passcode_programmer: TIMEOUT_CYCLES must be at least 2");
  end

  function automatic logic [3:0] get_digit(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] d;
    case (i)
      2'd0:    d = v[15:12];
      2'd1:    d = v[11:8];
      2'd2:    d = v[7:4];
      default: d = v[3:0];
    endcase
    return d;
  endfunction

  function automatic logic [15:0] put_digit(input logic [15:0] v, input logic [1:0] i,
                                            input logic [3:0] d);
    logic [15:0] r;
    r = v;
    case (i)
      2'd0:    r[15:12] = d;
      2'd1:    r[11:8]  = d;
      2'd2:    r[7:4]   = d;
      default: r[3:0]   = d;
    endcase
    return r;
  endfunction

  state_t      state;
  logic        s1;
  logic        s2;
  logic        press;
  logic [15:0] stage;
  logic        mm;
  logic [1:0]  idx;
  logic        mm_total;
  logic        timeout_hit;
  logic        abort_req;

  // One press per low-going edge of the (inverted) button.
  assign press = s1 & ~s2;

  // Mismatch including the digit being confirmed right now, so the last
  // confirmation digit takes part in the commit decision.
  assign mm_total = mm | (SW != get_digit(stage, idx));

  // prog_en low wins over a press; a press wins over the timeout.
  assign abort_req = (state != ST_IDLE) && (!prog_en || (!press && timeout_hit));

`ifdef PASSCODE_PROG_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr;

  // Held at zero in IDLE, so entering NEW starts from a cleared count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if (state == ST_IDLE || press) begin
      tmr <= '0;
    end else if (tmr != TMR_LAST) begin
      tmr <= tmr + TW'(1);
    end
  end

  assign timeout_hit = (state != ST_IDLE) && (tmr == TMR_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      stage      <= 16'h0000;
      mm         <= 1'b0;
      code       <= DEFAULT_CODE;
      prog_done  <= 1'b0;
      prog_error <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
    end else begin
      s1         <= ~btn0;
      s2         <= s1;
      prog_done  <= 1'b0;
      prog_error <= 1'b0;
      if (abort_req) begin
        state      <= ST_IDLE;
        idx        <= 2'd0;
        stage      <= 16'h0000;
        mm         <= 1'b0;
        prog_error <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (press && prog_en) begin
              state <= ST_NEW;
              idx   <= 2'd0;
              mm    <= 1'b0;
            end
          end
          ST_NEW: begin
            if (press) begin
              stage <= put_digit(stage, idx, SW);
              idx   <= idx + 2'd1;
              if (idx == 2'd3) begin
                state <= ST_CONFIRM;
              end
            end
          end
          ST_CONFIRM: begin
            if (press) begin
              idx <= idx + 2'd1;
              if (idx == 2'd3) begin
                state <= ST_IDLE;
                mm    <= 1'b0;
                if (mm_total) begin
                  prog_error <= 1'b1;
                end else begin
                  code      <= stage;
                  prog_done <= 1'b1;
                end
              end else begin
                mm <= mm_total;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            idx   <= 2'd0;
          end
        endcase
      end
    end
  end

  assign prog_state = state;
  assign digit_idx  = idx;
  assign led        = (state == ST_IDLE) ? 4'b0000 : (4'b1000 >> idx);

endmodule
